mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 26 ++
 rtl/mem_arbiter_if.sv | 32 +++
 rtl/mem_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared constants and types for the unified-memory arbiter and the core controller.
package mem_arbiter_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned CNT_W    = 3;
  localparam int unsigned WAIT_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACC_CORE = 2'd1,
    ST_ACC_LDR  = 2'd2,
    ST_RESP     = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_LDR  = 1'b1
  } owner_e;

  // Round-robin pick: core wins when alone, or on a tie when the loader was served last.
  function automatic owner_e rr_pick(logic core_req, logic ldr_req, owner_e last_served);
    return (core_req && (!ldr_req || last_served == OWN_LDR)) ? OWN_CORE : OWN_LDR;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Core, loader and memory signal bundle of the arbiter.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
;
  logic              core_req, core_we, core_ready;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata, core_rdata;
  logic              ldr_req, ldr_we, ldr_ready;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata, ldr_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              mem_we;
  logic              owner;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
    input  mem_rdata,
    output core_rdata, core_ready, ldr_rdata, ldr_ready,
    output mem_addr, mem_wdata, mem_we, owner
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata,
    output mem_rdata,
    input  core_rdata, core_ready, ldr_rdata, ldr_ready,
    input  mem_addr, mem_wdata, mem_we, owner
  );

endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (core / loader) round-robin arbiter for a shared unified memory
// with a fixed WAIT-cycle access and a one-cycle response.
//
// state       | meaning
// ST_IDLE     | waiting for a request, memory bus parked at 0
// ST_ACC_CORE | WAIT-cycle memory access on behalf of the core
// ST_ACC_LDR  | WAIT-cycle memory access on behalf of the loader
// ST_RESP     | ready pulse to the granted requester, requests ignored
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned WAIT = WAIT_DEF
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT - 1);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] core_rdata_q, core_rdata_d, ldr_rdata_q, ldr_rdata_d;
  logic              we_q, we_d, mem_we_q, mem_we_d;
  logic              core_ready_q, core_ready_d, ldr_ready_q, ldr_ready_d;
  owner_e            owner_q, owner_d, last_q, last_d;
  owner_e            pick;

  assign pick = rr_pick(bus.core_req, bus.ldr_req, last_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      mem_we_q     <= 1'b0;
      core_rdata_q <= '0;
      ldr_rdata_q  <= '0;
      core_ready_q <= 1'b0;
      ldr_ready_q  <= 1'b0;
      owner_q      <= OWN_CORE;
      last_q       <= OWN_LDR;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      mem_we_q     <= mem_we_d;
      core_rdata_q <= core_rdata_d;
      ldr_rdata_q  <= ldr_rdata_d;
      core_ready_q <= core_ready_d;
      ldr_ready_q  <= ldr_ready_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    mem_we_d     = 1'b0;
    core_rdata_d = core_rdata_q;
    ldr_rdata_d  = ldr_rdata_q;
    core_ready_d = 1'b0;
    ldr_ready_d  = 1'b0;
    owner_d      = owner_q;
    last_d       = last_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.core_req || bus.ldr_req) begin
          state_d  = (pick == OWN_CORE) ? ST_ACC_CORE : ST_ACC_LDR;
          owner_d  = pick;
          cnt_d    = '0;
          addr_d   = (pick == OWN_CORE) ? bus.core_addr  : bus.ldr_addr;
          wdata_d  = (pick == OWN_CORE) ? bus.core_wdata : bus.ldr_wdata;
          we_d     = (pick == OWN_CORE) ? bus.core_we    : bus.ldr_we;
          mem_we_d = we_d;
        end
      end
      ST_ACC_CORE, ST_ACC_LDR: begin
        cnt_d = cnt_q + 1'b1;
        // Last access cycle: capture read data and park the memory bus.
        if (cnt_q == CNT_LAST) begin
          state_d = ST_RESP;
          addr_d  = '0;
          wdata_d = '0;
          if (state_q == ST_ACC_CORE) begin
            core_ready_d = 1'b1;
            if (!we_q) core_rdata_d = bus.mem_rdata;
          end else begin
            ldr_ready_d = 1'b1;
            if (!we_q) ldr_rdata_d = bus.mem_rdata;
          end
        end
      end
      ST_RESP: begin
        last_d  = owner_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.core_rdata = core_rdata_q;
  assign bus.ldr_rdata  = ldr_rdata_q;
  assign bus.core_ready = core_ready_q;
  assign bus.ldr_ready  = ldr_ready_q;
  assign bus.owner      = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Drives three arbiters (WAIT = 1, 2, 7) with shared stimulus and compares them
// cycle by cycle against a transaction-level timing model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int NK = 3;

  function automatic int wait_of(int k);
    return (k == 0) ? 1 : (k == 1) ? 2 : 7;
  endfunction

  typedef struct packed {
    logic        creq, cwe;
    logic [31:0] caddr, cwd;
    logic        lreq, lwe;
    logic [31:0] laddr, lwd;
    logic [31:0] mrd;
  } stim_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  stim_t cur = '0;
  stim_t nx  = '0;
  int    cyc = 0;
  int    n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  logic [31:0] o_crd [NK], o_lrd [NK], o_maddr [NK], o_mwd [NK];
  logic        o_crdy [NK], o_lrdy [NK], o_mwe [NK], o_own [NK];

  mem_arbiter_if bus [NK] ();

  for (genvar g = 0; g < NK; g++) begin : g_dut
    mem_arbiter #(.WAIT(wait_of(g))) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus[g])
    );
    assign bus[g].core_req   = cur.creq;
    assign bus[g].core_we    = cur.cwe;
    assign bus[g].core_addr  = cur.caddr;
    assign bus[g].core_wdata = cur.cwd;
    assign bus[g].ldr_req    = cur.lreq;
    assign bus[g].ldr_we     = cur.lwe;
    assign bus[g].ldr_addr   = cur.laddr;
    assign bus[g].ldr_wdata  = cur.lwd;
    assign bus[g].mem_rdata  = cur.mrd;
    assign o_crd[g]   = bus[g].core_rdata;
    assign o_lrd[g]   = bus[g].ldr_rdata;
    assign o_crdy[g]  = bus[g].core_ready;
    assign o_lrdy[g]  = bus[g].ldr_ready;
    assign o_maddr[g] = bus[g].mem_addr;
    assign o_mwd[g]   = bus[g].mem_wdata;
    assign o_mwe[g]   = bus[g].mem_we;
    assign o_own[g]   = bus[g].owner;
  end

  // Transaction model: one outstanding grant per arbiter, described by its grant cycle.
  int          free_at [NK];
  bit          act [NK];
  int          g_cyc [NK];
  bit          g_own [NK];
  bit          g_we [NK];
  logic [31:0] g_addr [NK], g_wd [NK];
  logic [31:0] e_crd [NK], e_lrd [NK];
  bit          e_own [NK];
  bit          last_srv [NK];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < NK; k++) begin
      act[k] = 1'b0; free_at[k] = cyc; e_crd[k] = '0; e_lrd[k] = '0;
      e_own[k] = 1'b0; last_srv[k] = 1'b1;
    end
  endtask

  task automatic check_reset_zero();
    for (int k = 0; k < NK; k++) begin
      chk($sformatf("w%0d.rst_mem_addr", wait_of(k)), o_maddr[k], 32'h0);
      chk($sformatf("w%0d.rst_mem_wdata", wait_of(k)), o_mwd[k], 32'h0);
      chk($sformatf("w%0d.rst_mem_we", wait_of(k)), 32'(o_mwe[k]), 32'h0);
      chk($sformatf("w%0d.rst_readys", wait_of(k)), {30'h0, o_crdy[k], o_lrdy[k]}, 32'h0);
      chk($sformatf("w%0d.rst_core_rdata", wait_of(k)), o_crd[k], 32'h0);
      chk($sformatf("w%0d.rst_ldr_rdata", wait_of(k)), o_lrd[k], 32'h0);
      chk($sformatf("w%0d.rst_owner", wait_of(k)), 32'(o_own[k]), 32'h0);
    end
  endtask

  task automatic check_outputs(input int c);
    for (int k = 0; k < NK; k++) begin
      int  w = wait_of(k);
      bit  in_acc = act[k] && c >= g_cyc[k] + 1 && c <= g_cyc[k] + w;
      bit  resp   = act[k] && c == g_cyc[k] + w + 1;
      chk($sformatf("w%0d.mem_addr", w), o_maddr[k], in_acc ? g_addr[k] : 32'h0);
      chk($sformatf("w%0d.mem_wdata", w), o_mwd[k], in_acc ? g_wd[k] : 32'h0);
      chk($sformatf("w%0d.mem_we", w), 32'(o_mwe[k]),
          32'(act[k] && g_we[k] && c == g_cyc[k] + 1));
      chk($sformatf("w%0d.core_ready", w), 32'(o_crdy[k]), 32'(resp && g_own[k] == 1'b0));
      chk($sformatf("w%0d.ldr_ready", w), 32'(o_lrdy[k]), 32'(resp && g_own[k] == 1'b1));
      chk($sformatf("w%0d.core_rdata", w), o_crd[k], e_crd[k]);
      chk($sformatf("w%0d.ldr_rdata", w), o_lrd[k], e_lrd[k]);
      chk($sformatf("w%0d.owner", w), 32'(o_own[k]), 32'(e_own[k]));
    end
  endtask

  task automatic model_step(input int c);
    for (int k = 0; k < NK; k++) begin
      int w = wait_of(k);
      if (act[k] && c == g_cyc[k] + w && !g_we[k]) begin
        if (g_own[k]) e_lrd[k] = cur.mrd;
        else          e_crd[k] = cur.mrd;
      end
      if (act[k] && c == g_cyc[k] + w + 1) begin
        last_srv[k] = g_own[k];
        act[k]      = 1'b0;
      end
      if (c >= free_at[k] && (cur.creq || cur.lreq)) begin
        g_own[k]   = (cur.creq && cur.lreq) ? ~last_srv[k] : cur.lreq;
        g_we[k]    = g_own[k] ? cur.lwe   : cur.cwe;
        g_addr[k]  = g_own[k] ? cur.laddr : cur.caddr;
        g_wd[k]    = g_own[k] ? cur.lwd   : cur.cwd;
        g_cyc[k]   = c;
        act[k]     = 1'b1;
        e_own[k]   = g_own[k];
        free_at[k] = c + w + 2;
      end
    end
  endtask

  task automatic step(input bit do_rst);
    @(negedge clk);
    if (do_rst) begin
      #2 rst = 1'b1;
      #1 check_reset_zero();
      @(negedge clk);
      rst = 1'b0;
      cyc++;
      model_reset();
    end
    check_outputs(cyc);
    cur = nx;
    model_step(cyc);
    cyc++;
  endtask

  function automatic stim_t rand_stim(int pct_c, int pct_l);
    stim_t s;
    s.creq  = ($urandom_range(0, 99) < pct_c);
    s.cwe   = $urandom_range(0, 1) == 1;
    s.caddr = $urandom;
    s.cwd   = $urandom;
    s.lreq  = ($urandom_range(0, 99) < pct_l);
    s.lwe   = $urandom_range(0, 1) == 1;
    s.laddr = $urandom;
    s.lwd   = $urandom;
    s.mrd   = $urandom;
    return s;
  endfunction

  initial begin
    repeat (2) @(negedge clk);
    check_reset_zero();
    rst = 1'b0;
    cyc = 0;
    model_reset();

    nx = '0;
    step(1'b0);
    // Core read of 0x40, request held for one cycle only; memory returns DEADBEEF.
    nx = '0; nx.creq = 1'b1; nx.caddr = 32'h40; nx.mrd = $urandom;
    step(1'b0);
    nx = '0; nx.mrd = 32'hDEADBEEF;
    repeat (10) step(1'b0);
    // Loader write 0x12345678 to 0x100.
    nx = '0; nx.lreq = 1'b1; nx.lwe = 1'b1; nx.laddr = 32'h100; nx.lwd = 32'h12345678;
    step(1'b0);
    nx = '0; nx.mrd = $urandom;
    repeat (10) step(1'b0);
    // Core read, then reset during the second access cycle of the WAIT=2 arbiter.
    nx = '0; nx.creq = 1'b1; nx.caddr = 32'h80; nx.mrd = 32'h5555AAAA;
    step(1'b0);
    nx = '0; nx.mrd = 32'h5555AAAA;
    step(1'b0);
    step(1'b1);
    // Both requests held from reset: grants alternate core, loader, core.
    for (int i = 0; i < 40; i++) begin
      nx = rand_stim(100, 100);
      step(1'b0);
    end
    for (int i = 0; i < 2000; i++) begin
      nx = rand_stim(45, 35);
      step($urandom_range(0, 199) == 0);
    end
    nx = '0;
    repeat (12) step(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
